lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Sequential memory-access engine for the load/store unit. It sits between execute and the data-memory bus. It accepts one decoded load/store (size, signedness, computed address, store data, destination register) per transaction and checks alignment. It then issues a byte-lane-masked request over a valid/ready memory handshake. For loads, it waits for read data, then extracts and sign/zero-extends it and returns a single-cycle writeback.

## Interface
- ADDR_W, 32, byte-address width of req_addr and mem_addr
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  execute presents a memory op
- req_ready  out  1  block can accept (high only in IDLE)
- req_is_load  in  1  1 = load, 0 = store
- req_zero_ext  in  1  1 = LBU/LHU (zero-extend), 0 = sign-extend; ignored for stores and words
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_addr  in  ADDR_W  effective byte address (rs1 + imm, computed in execute)
- req_wdata  in  32  store data, right-aligned
- req_rd  in  5  load destination register
- mem_valid  out  1  request to data memory
- mem_ready  in  1  memory accepts request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data valid (one cycle)
- mem_rdata  in  32  read word
- wb_valid  out  1  load result valid, one-cycle pulse, no backpressure
- wb_rd  out  5  destination register
- wb_data  out  32  extended load result
- misalign  out  1  one-cycle pulse: op rejected (misaligned or size 11)

## Operation
- FSM states: IDLE, REQ, WAIT_R, WB, ERR.
- IDLE: req_ready=1. On req_valid, latch all req_* fields. Go to ERR if misaligned, else go to REQ.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0; any size 11.
- ERR: misalign=1 for one cycle, with no memory access and no writeback. Then return to IDLE.
- REQ: mem_valid=1. mem_we, mem_addr, mem_be and mem_wdata are held stable until mem_ready. On mem_valid&&mem_ready, a store goes to IDLE and a load goes to WAIT_R.
- WAIT_R: wait for mem_rvalid. Capture the extracted result and go to WB.
- WB: wb_valid=1 with wb_rd/wb_data for one cycle, then go to IDLE. rd=0 still pulses wb_valid; the register file ignores it.
- Byte-enable (lane = addr[1:0]):
  - byte: be = 0001<<lane, wdata = {4{d[7:0]}}
  - half: be = 0011<<(2·addr[1]), wdata = {2{d[15:0]}}
  - word: be = 1111, wdata = d
- Load extract:
  - byte = rdata[8·lane +: 8]
  - half = rdata[16·addr[1] +: 16]
  - Extend to 32 bits with zeros if zero_ext, else with the MSB. Word is passed through.
- mem_rvalid outside WAIT_R is ignored.
- Outputs not named as active in a state are 0: mem_valid, mem_we, mem_be, wb_valid, misalign. mem_addr, mem_wdata, wb_rd and wb_data are don't-care except when their qualifying valid is high.

## Timing
- Reset values: state IDLE, req_ready=1. All other outputs are 0, including mem_valid, mem_we, mem_addr, mem_be, mem_wdata, wb_valid, wb_rd, wb_data and misalign.
- Accept at edge T → mem_valid high in cycle T+1.
- Store, best case: mem_ready in T+1 → req_ready again in T+2 (2 cycles per store).
- Load, best case: mem_ready in T+1, mem_rvalid in T+2 → wb_valid in T+3, req_ready in T+4.
- Misaligned: misalign in T+1, req_ready in T+2.
- Memory stall: mem_valid stays high with unchanged payload for any number of cycles.
- mem_rvalid in the same cycle as the mem_ready handshake is not accepted. Read data must arrive at least one cycle after the handshake.
- rst mid-operation: next edge forces IDLE and deasserts mem_valid and wb_valid. Any late mem_rvalid for the aborted load is then ignored in IDLE.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, mem_ready immediate → mem_addr 0x100, be 1111, wdata 0xDEADBEEF, we=1. req_ready back 2 cycles after accept. No wb_valid.
- SB addr 0x103, data 0x000000A5 → mem_addr 0x100, be 1000, wdata 0xA5A5A5A5. SH addr 0x102, data 0x1234 → be 1100, wdata 0x12341234.
- LB addr 0x101, rd 7, rdata 0x0000_80_00 → wb_rd 7, wb_data 0xFFFFFF80. Same with zero_ext=1 → 0x00000080. LH addr 0x102, rdata 0x8001_0000, zero_ext=0 → 0xFFFF8001.
- LW addr 0x102 → misalign pulse 1 cycle, mem_valid never asserted, no wb_valid. size 11 at addr 0x0 → same.
- LW with mem_ready held low 5 cycles, then rvalid 3 cycles after handshake → mem_valid and payload stable throughout, exactly one wb_valid. A stray rvalid in IDLE is ignored.
- rst asserted while in WAIT_R → next cycle IDLE, req_ready=1. A subsequent rvalid produces no wb_valid.

Source files
------------

// File: rtl/lsu_mem_port_if.sv
// Bus bundle for the load/store memory port: execute request, data-memory bus, and writeback.
// Valid/ready: a transfer happens on a rising edge where both are high; the source holds its payload stable while valid is high and ready is low.
interface lsu_mem_port_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_is_load;
    logic              req_zero_ext;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              misalign;

    // master: the load/store port itself; slave: execute, memory and register file around it
    modport master (
        input  req_valid, req_is_load, req_zero_ext, req_size, req_addr, req_wdata, req_rd,
        output req_ready,
        output mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output wb_valid, wb_rd, wb_data, misalign
    );

    modport slave (
        output req_valid, req_is_load, req_zero_ext, req_size, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  wb_valid, wb_rd, wb_data, misalign
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Sequential load/store engine: alignment check, lane-masked memory request, load extract and writeback.
module lsu_mem_port #(
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    lsu_mem_port_if.master       bus,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT_R = 3'd2,
        S_WB     = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t state, state_nx;

    logic              lat_is_load;
    logic              lat_zero_ext;
    logic [1:0]        lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [4:0]        lat_rd;
    logic [31:0]       wb_data_q;

    logic              req_bad;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [31:0]       load_ext;

    assign dbg_state = state;

    // Alignment is judged on the incoming request so the decision is ready at accept.
    always_comb begin
        req_bad = 1'b0;
        case (bus.req_size)
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = bus.req_addr[0];
            2'b10:   req_bad = |bus.req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
    end

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = lat_wdata;
        case (lat_size)
            2'b00: begin
                be_c    = 4'b0001 << lat_addr[1:0];
                wdata_c = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = lat_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{lat_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = lat_wdata;
            end
        endcase
    end

    always_comb begin
        rbyte    = bus.mem_rdata[8*lat_addr[1:0] +: 8];
        rhalf    = lat_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        load_ext = bus.mem_rdata;
        case (lat_size)
            2'b00:   load_ext = {{24{~lat_zero_ext & rbyte[7]}}, rbyte};
            2'b01:   load_ext = {{16{~lat_zero_ext & rhalf[15]}}, rhalf};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_is_load  <= 1'b0;
            lat_zero_ext <= 1'b0;
            lat_size     <= 2'b00;
            lat_addr     <= '0;
            lat_wdata    <= 32'h0;
            lat_rd       <= 5'd0;
            wb_data_q    <= 32'h0;
        end else begin
            if (state == S_IDLE && bus.req_valid) begin
                lat_is_load  <= bus.req_is_load;
                lat_zero_ext <= bus.req_zero_ext;
                lat_size     <= bus.req_size;
                lat_addr     <= bus.req_addr;
                lat_wdata    <= bus.req_wdata;
                lat_rd       <= bus.req_rd;
            end
            if (state == S_WAIT_R && bus.mem_rvalid) begin
                wb_data_q <= load_ext;
            end
        end
    end

    // Payload outputs are gated by state so they read zero whenever their valid is low.
    always_comb begin
        state_nx      = state;
        bus.req_ready = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_be    = 4'b0000;
        bus.mem_wdata = 32'h0;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = 5'd0;
        bus.wb_data   = 32'h0;
        bus.misalign  = 1'b0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nx = req_bad ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                bus.mem_valid = 1'b1;
                bus.mem_we    = ~lat_is_load;
                bus.mem_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
                bus.mem_be    = be_c;
                bus.mem_wdata = lat_is_load ? 32'h0 : wdata_c;
                if (bus.mem_ready) begin
                    state_nx = lat_is_load ? S_WAIT_R : S_IDLE;
                end
            end
            S_WAIT_R: begin
                if (bus.mem_rvalid) begin
                    state_nx = S_WB;
                end
            end
            S_WB: begin
                bus.wb_valid = 1'b1;
                bus.wb_rd    = lat_rd;
                bus.wb_data  = wb_data_q;
                state_nx     = S_IDLE;
            end
            S_ERR: begin
                bus.misalign = 1'b1;
                state_nx     = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: stores, loads, misalignment, stalls, stray read data and reset abort.
module tb_lsu_mem_port;

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;
    int         total;
    int         bad;

    lsu_mem_port_if #(.ADDR_W(32)) bus ();

    lsu_mem_port #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Presents one request at the current falling edge; returns one cycle later with req_valid dropped.
    task automatic issue(input logic ld, input logic zx, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        bus.req_valid    = 1'b1;
        bus.req_is_load  = ld;
        bus.req_zero_ext = zx;
        bus.req_size     = sz;
        bus.req_addr     = a;
        bus.req_wdata    = d;
        bus.req_rd       = rd;
        @(negedge clk);
        bus.req_valid    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready);
        end
        total++;
        if ({bus.mem_valid, bus.mem_we, bus.mem_be, bus.wb_valid, bus.misalign} !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctrl got mv=%b we=%b be=%b wbv=%b mis=%b exp all 0",
                     bus.mem_valid, bus.mem_we, bus.mem_be, bus.wb_valid, bus.misalign);
        end
        total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.wb_rd, bus.wb_data} !== 101'h0) begin
            bad++;
            $display("FAIL reset_data got addr=%h wdata=%h rd=%0d wbdata=%h exp 0",
                     bus.mem_addr, bus.mem_wdata, bus.wb_rd, bus.wb_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stores();
        logic [31:0] a_t  [3] = '{32'h100, 32'h103, 32'h102};
        logic [1:0]  s_t  [3] = '{2'b10, 2'b00, 2'b01};
        logic [31:0] d_t  [3] = '{32'hDEADBEEF, 32'h000000A5, 32'h00001234};
        logic [3:0]  be_t [3] = '{4'b1111, 4'b1000, 4'b1100};
        logic [31:0] w_t  [3] = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'h12341234};
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 1'b0, s_t[i], a_t[i], d_t[i], 5'd0);
            total++;
            if (bus.mem_valid !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h100 ||
                bus.mem_be !== be_t[i] || bus.mem_wdata !== w_t[i]) begin
                bad++;
                $display("FAIL store%0d_req got mv=%b we=%b addr=%h be=%b wd=%h exp mv=1 we=1 addr=00000100 be=%b wd=%h",
                         i, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata, be_t[i], w_t[i]);
            end
            bus.mem_ready = 1'b1;
            @(negedge clk);
            bus.mem_ready = 1'b0;
            total++;
            if (bus.req_ready !== 1'b1 || bus.mem_valid !== 1'b0 || bus.wb_valid !== 1'b0) begin
                bad++;
                $display("FAIL store%0d_done got rr=%b mv=%b wbv=%b exp rr=1 mv=0 wbv=0",
                         i, bus.req_ready, bus.mem_valid, bus.wb_valid);
            end
        end
    endtask

    task automatic test_loads();
        logic [31:0] a_t  [5] = '{32'h101, 32'h101, 32'h102, 32'h104, 32'h100};
        logic [1:0]  s_t  [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01};
        logic        z_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [4:0]  rd_t [5] = '{5'd7, 5'd7, 5'd12, 5'd0, 5'd31};
        logic [31:0] r_t  [5] = '{32'h00008000, 32'h00008000, 32'h80010000, 32'h12345678, 32'h0000F00F};
        logic [3:0]  be_t [5] = '{4'b0010, 4'b0010, 4'b1100, 4'b1111, 4'b0011};
        logic [31:0] e_t  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h12345678, 32'h0000F00F};
        logic [31:0] wa;
        for (int i = 0; i < 5; i++) begin
            wa = {a_t[i][31:2], 2'b00};
            issue(1'b1, z_t[i], s_t[i], a_t[i], 32'hFFFFFFFF, rd_t[i]);
            total++;
            if (bus.mem_valid !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== wa || bus.mem_be !== be_t[i]) begin
                bad++;
                $display("FAIL load%0d_req got mv=%b we=%b addr=%h be=%b exp mv=1 we=0 addr=%h be=%b",
                         i, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_be, wa, be_t[i]);
            end
            bus.mem_ready = 1'b1;
            @(negedge clk);
            bus.mem_ready  = 1'b0;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = r_t[i];
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'h0;
            total++;
            if (bus.wb_valid !== 1'b1 || bus.wb_rd !== rd_t[i] || bus.wb_data !== e_t[i]) begin
                bad++;
                $display("FAIL load%0d_wb got wbv=%b rd=%0d data=%h exp wbv=1 rd=%0d data=%h",
                         i, bus.wb_valid, bus.wb_rd, bus.wb_data, rd_t[i], e_t[i]);
            end
            @(negedge clk);
            total++;
            if (bus.req_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
                bad++;
                $display("FAIL load%0d_done got rr=%b wbv=%b exp rr=1 wbv=0", i, bus.req_ready, bus.wb_valid);
            end
        end
    endtask

    task automatic test_misalign();
        logic        l_t [3] = '{1'b1, 1'b1, 1'b0};
        logic [1:0]  s_t [3] = '{2'b10, 2'b11, 2'b01};
        logic [31:0] a_t [3] = '{32'h102, 32'h000, 32'h101};
        for (int i = 0; i < 3; i++) begin
            issue(l_t[i], 1'b0, s_t[i], a_t[i], 32'h55AA55AA, 5'd4);
            total++;
            if (bus.misalign !== 1'b1 || bus.mem_valid !== 1'b0 || bus.wb_valid !== 1'b0) begin
                bad++;
                $display("FAIL misalign%0d_pulse got mis=%b mv=%b wbv=%b exp mis=1 mv=0 wbv=0",
                         i, bus.misalign, bus.mem_valid, bus.wb_valid);
            end
            @(negedge clk);
            total++;
            if (bus.misalign !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_valid !== 1'b0 || bus.wb_valid !== 1'b0) begin
                bad++;
                $display("FAIL misalign%0d_after got mis=%b rr=%b mv=%b wbv=%b exp mis=0 rr=1 mv=0 wbv=0",
                         i, bus.misalign, bus.req_ready, bus.mem_valid, bus.wb_valid);
            end
        end
    endtask

    task automatic test_stall();
        int          pulses;
        logic [31:0] got;
        logic [4:0]  got_rd;
        issue(1'b1, 1'b0, 2'b10, 32'h200, 32'h0, 5'd3);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus.mem_valid !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h200 || bus.mem_be !== 4'b1111) begin
                bad++;
                $display("FAIL stall_hold%0d got mv=%b we=%b addr=%h be=%b exp mv=1 we=0 addr=00000200 be=1111",
                         i, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_be);
            end
            @(negedge clk);
        end
        // Read data coinciding with the handshake must be ignored.
        bus.mem_ready  = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD0BAD0;
        @(negedge clk);
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 32'hCAFEF00D;
        pulses = 0;
        got    = 32'h0;
        got_rd = 5'd0;
        for (int k = 0; k < 8; k++) begin
            bus.mem_rvalid = (k == 2);
            @(negedge clk);
            if (bus.wb_valid === 1'b1) begin
                pulses++;
                got    = bus.wb_data;
                got_rd = bus.wb_rd;
            end
        end
        bus.mem_rvalid = 1'b0;
        total++;
        if (pulses != 1 || got !== 32'hCAFEF00D || got_rd !== 5'd3) begin
            bad++;
            $display("FAIL stall_wb got pulses=%0d data=%h rd=%0d exp pulses=1 data=cafef00d rd=3", pulses, got, got_rd);
        end
        bus.mem_rvalid = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.wb_valid === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0 || bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL stray_rvalid got pulses=%0d rr=%b exp pulses=0 rr=1", pulses, bus.req_ready);
        end
    endtask

    task automatic test_back_to_back();
        bus.req_valid    = 1'b1;
        bus.req_is_load  = 1'b0;
        bus.req_zero_ext = 1'b0;
        bus.req_size     = 2'b10;
        bus.req_addr     = 32'h40;
        bus.req_wdata    = 32'h11223344;
        bus.req_rd       = 5'd0;
        @(negedge clk);
        // Next op is already waiting while the store is in flight.
        bus.req_is_load  = 1'b1;
        bus.req_zero_ext = 1'b1;
        bus.req_size     = 2'b00;
        bus.req_addr     = 32'h41;
        bus.req_wdata    = 32'h0;
        bus.req_rd       = 5'd5;
        total++;
        if (bus.req_ready !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h11223344 || bus.mem_addr !== 32'h40) begin
            bad++;
            $display("FAIL b2b_store got rr=%b we=%b wd=%h addr=%h exp rr=0 we=1 wd=11223344 addr=00000040",
                     bus.req_ready, bus.mem_we, bus.mem_wdata, bus.mem_addr);
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        total++;
        if (bus.mem_valid !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'b0010 || bus.mem_addr !== 32'h40) begin
            bad++;
            $display("FAIL b2b_load_req got mv=%b we=%b be=%b addr=%h exp mv=1 we=0 be=0010 addr=00000040",
                     bus.mem_valid, bus.mem_we, bus.mem_be, bus.mem_addr);
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h00009900;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        total++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_data !== 32'h00000099) begin
            bad++;
            $display("FAIL b2b_load_wb got wbv=%b rd=%0d data=%h exp wbv=1 rd=5 data=00000099",
                     bus.wb_valid, bus.wb_rd, bus.wb_data);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_abort();
        int pulses;
        issue(1'b1, 1'b0, 2'b10, 32'h300, 32'h0, 5'd9);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (bus.req_ready !== 1'b1 || bus.mem_valid !== 1'b0 || bus.wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_abort got rr=%b mv=%b wbv=%b exp rr=1 mv=0 wbv=0", bus.req_ready, bus.mem_valid, bus.wb_valid);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h77777777;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        pulses = (bus.wb_valid === 1'b1) ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.wb_valid === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL rst_late_rvalid got pulses=%0d exp 0", pulses);
        end
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_is_load  = 1'b0;
        bus.req_zero_ext = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.req_rd       = 5'd0;
        bus.mem_ready    = 1'b0;
        bus.mem_rvalid   = 1'b0;
        bus.mem_rdata    = 32'h0;
        test_reset();
        test_stores();
        test_loads();
        test_misalign();
        test_stall();
        test_back_to_back();
        test_rst_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
